// File: rtl/hs_tx_ddr_serializer_pkg.sv
// Shared definitions for the D-PHY HS transmit path: sync byte, state encodings
// and default framing lengths, also used by the receiver's sync detector.
package hs_tx_ddr_serializer_pkg;

    localparam int         BYTE_W               = 8;
    localparam logic [7:0] SYNC_BYTE            = 8'hB8;
    localparam int         ZERO_CYCLES_DEFAULT  = 6;
    localparam int         TRAIL_CYCLES_DEFAULT = 4;
    localparam logic [1:0] LAST_PAIR            = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ZERO  = 3'd1,
        ST_SYNC  = 3'd2,
        ST_DATA  = 3'd3,
        ST_TRAIL = 3'd4
    } tx_state_e;

    function automatic logic [BYTE_W-1:0] fillByte(input logic bitVal);
        return {BYTE_W{bitVal}};
    endfunction

endpackage

// File: rtl/hs_tx_ddr_serializer_pair_shifter.sv
// Byte load/shift register emitting one bit pair per cycle, LSB pair first,
// with a pair counter that restarts on every load.
module hs_tx_pair_shifter
    import hs_tx_ddr_serializer_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [BYTE_W-1:0] loadData_i,
    input  logic              shift_i,
    output logic              pairB1_o,
    output logic              pairB2_o,
    output logic [1:0]        pairCnt_o
);

    logic [BYTE_W-1:0] shift_q;
    logic [1:0]        pairCnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q   <= '0;
            pairCnt_q <= '0;
        end else if (load_i) begin
            shift_q   <= loadData_i;
            pairCnt_q <= '0;
        end else if (shift_i) begin
            shift_q   <= {2'b00, shift_q[BYTE_W-1:2]};
            pairCnt_q <= pairCnt_q + 2'd1;
        end
    end

    // The low two flops drive the line directly, so the pair outputs are registered.
    assign pairB1_o  = shift_q[0];
    assign pairB2_o  = shift_q[1];
    assign pairCnt_o = pairCnt_q;

endmodule

// File: rtl/hs_tx_ddr_serializer.sv
// D-PHY HS transmit serializer: HS-zero, sync byte, payload and HS-trail framing.
// Optional HS_TX_BYTE_CNT_EN adds a saturating per-burst accepted-byte counter.
module hs_tx_ddr_serializer
    import hs_tx_ddr_serializer_pkg::*;
#(
    parameter int ZERO_CYCLES  = ZERO_CYCLES_DEFAULT,
    parameter int TRAIL_CYCLES = TRAIL_CYCLES_DEFAULT
) (
    input  logic        TxDDRClkHS,
    input  logic        TxRst,
    input  logic        TxRequestHS,
    input  logic [7:0]  TxDataHS,
    output logic        TxReadyHS,
    output logic        serial_B1,
    output logic        serial_B2,
    output logic        hs_drv_en,
    output logic        tx_active
`ifdef HS_TX_BYTE_CNT_EN
    ,
    output logic [15:0] tx_byte_cnt
`endif
);

    localparam logic [7:0] ZERO_LOAD  = 8'(ZERO_CYCLES - 1);
    localparam logic [7:0] TRAIL_LOAD = 8'(TRAIL_CYCLES - 1);

    tx_state_e   state_q;
    logic [7:0]  phaseCnt_q;
    logic        hsDrvEn_q;
    logic        txActive_q;

    logic        shLoad;
    logic        shShift;
    logic [7:0]  shData;
    logic        pairB1;
    logic        pairB2;
    logic [1:0]  pairCnt;
    logic        lastPair;
    logic        trailBit;

    assign lastPair  = ((state_q == ST_SYNC) || (state_q == ST_DATA)) && (pairCnt == LAST_PAIR);
    assign TxReadyHS = lastPair && TxRequestHS;
    assign trailBit  = ~pairB2;

    // The trail level is latched by loading it into every bit of the shifter.
    always_comb begin
        shLoad  = 1'b0;
        shShift = 1'b0;
        shData  = '0;
        case (state_q)
            ST_ZERO: begin
                if (phaseCnt_q == 8'd0) begin
                    shLoad = 1'b1;
                    shData = SYNC_BYTE;
                end
            end
            ST_SYNC, ST_DATA: begin
                if (!lastPair) begin
                    shShift = 1'b1;
                end else if (TxRequestHS) begin
                    shLoad = 1'b1;
                    shData = TxDataHS;
                end else begin
                    shLoad = 1'b1;
                    shData = fillByte(trailBit);
                end
            end
            ST_TRAIL: begin
                if (phaseCnt_q == 8'd0) begin
                    shLoad = 1'b1;
                    shData = '0;
                end
            end
            default: begin
                shLoad = 1'b0;
            end
        endcase
    end

    always_ff @(posedge TxDDRClkHS) begin
        if (TxRst) begin
            state_q    <= ST_IDLE;
            phaseCnt_q <= '0;
            hsDrvEn_q  <= 1'b0;
            txActive_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (TxRequestHS) begin
                        state_q    <= ST_ZERO;
                        phaseCnt_q <= ZERO_LOAD;
                        hsDrvEn_q  <= 1'b1;
                        txActive_q <= 1'b1;
                    end
                end
                ST_ZERO: begin
                    if (phaseCnt_q == 8'd0) begin
                        state_q <= ST_SYNC;
                    end else begin
                        phaseCnt_q <= phaseCnt_q - 8'd1;
                    end
                end
                ST_SYNC, ST_DATA: begin
                    if (lastPair) begin
                        if (TxRequestHS) begin
                            state_q <= ST_DATA;
                        end else begin
                            state_q    <= ST_TRAIL;
                            phaseCnt_q <= TRAIL_LOAD;
                        end
                    end
                end
                ST_TRAIL: begin
                    if (phaseCnt_q == 8'd0) begin
                        state_q    <= ST_IDLE;
                        hsDrvEn_q  <= 1'b0;
                        txActive_q <= 1'b0;
                    end else begin
                        phaseCnt_q <= phaseCnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    hsDrvEn_q  <= 1'b0;
                    txActive_q <= 1'b0;
                end
            endcase
        end
    end

    hs_tx_pair_shifter u_pairShifter (
        .clk_i      (TxDDRClkHS),
        .rst_i      (TxRst),
        .load_i     (shLoad),
        .loadData_i (shData),
        .shift_i    (shShift),
        .pairB1_o   (pairB1),
        .pairB2_o   (pairB2),
        .pairCnt_o  (pairCnt)
    );

    assign serial_B1 = pairB1;
    assign serial_B2 = pairB2;
    assign hs_drv_en = hsDrvEn_q;
    assign tx_active = txActive_q;

`ifdef HS_TX_BYTE_CNT_EN
    logic [15:0] byteCnt_q;
    logic [15:0] byteCnt_d;

    // Cleared as a new burst leaves IDLE, then held after the burst for readout.
    always_comb begin
        byteCnt_d = byteCnt_q;
        if ((state_q == ST_IDLE) && TxRequestHS) begin
            byteCnt_d = '0;
        end else if (TxReadyHS && (byteCnt_q != 16'hFFFF)) begin
            byteCnt_d = byteCnt_q + 16'd1;
        end
    end

    always_ff @(posedge TxDDRClkHS) begin
        if (TxRst) begin
            byteCnt_q <= '0;
        end else begin
            byteCnt_q <= byteCnt_d;
        end
    end

    assign tx_byte_cnt = byteCnt_q;
`endif

endmodule

// File: tb/tb_hs_tx_ddr_serializer.sv
// Directed bench for hs_tx_ddr_serializer: vector table of per-cycle expectations
// plus hand-written reset, request-hold and (with HS_TX_BYTE_CNT_EN) byte-count sequences.
module tb_hs_tx_ddr_serializer;

    localparam int ZC = 6;
    localparam int TC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [7:0]  data;
    logic        TxReadyHS;
    logic        serial_B1;
    logic        serial_B2;
    logic        hs_drv_en;
    logic        tx_active;
`ifdef HS_TX_BYTE_CNT_EN
    logic [15:0] tx_byte_cnt;
`endif

    always #5 clk = ~clk;

    hs_tx_ddr_serializer #(
        .ZERO_CYCLES  (ZC),
        .TRAIL_CYCLES (TC)
    ) dut (
        .TxDDRClkHS  (clk),
        .TxRst       (rst),
        .TxRequestHS (req),
        .TxDataHS    (data),
        .TxReadyHS   (TxReadyHS),
        .serial_B1   (serial_B1),
        .serial_B2   (serial_B2),
        .hs_drv_en   (hs_drv_en),
`ifdef HS_TX_BYTE_CNT_EN
        .tx_active   (tx_active),
        .tx_byte_cnt (tx_byte_cnt)
`else
        .tx_active   (tx_active)
`endif
    );

    // Expected outputs packed as {B1, B2, hs_drv_en, tx_active, TxReadyHS}.
    typedef struct {
        logic       req;
        logic [7:0] data;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   compared   = 0;
    int   mismatched = 0;

    function automatic logic [4:0] outs();
        return {serial_B1, serial_B2, hs_drv_en, tx_active, TxReadyHS};
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [7:0] d);
        req  = r;
        data = d;
        #1;
    endtask

    task automatic addVec(input logic r, input logic [7:0] d, input logic [4:0] e);
        vec_t v;
        v.req  = r;
        v.data = d;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    task automatic addZero(input logic r, input logic [7:0] d);
        for (int i = 0; i < ZC; i++) addVec(r, d, 5'b00110);
    endtask

    task automatic addTrail(input logic b, input logic r);
        for (int i = 0; i < TC; i++) addVec(r, 8'h00, {b, b, 3'b110});
    endtask

    // Sync pairs (0,0),(0,1),(1,1),(0,1); the last one handshakes when lastReq is set.
    task automatic addSync(input logic lastReq, input logic [7:0] lastData);
        addVec(1'b1, 8'h00, 5'b00110);
        addVec(1'b1, 8'h00, 5'b01110);
        addVec(1'b1, 8'h00, 5'b11110);
        addVec(lastReq, lastData, {4'b0111, lastReq});
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (tx_active && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " idle timeout"}, 16'(tx_active), 16'h0000);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int readyPulses;

        // Single byte 5A, request dropped mid-byte, trail (1,1)
        addVec(1'b1, 8'h5A, 5'b00000);
        addZero(1'b1, 8'h5A);
        addSync(1'b1, 8'h5A);
        addVec(1'b1, 8'h00, 5'b01110);
        addVec(1'b0, 8'h00, 5'b01110);
        addVec(1'b0, 8'h00, 5'b10110);
        addVec(1'b0, 8'h00, 5'b10110);
        addTrail(1'b1, 1'b0);
        addVec(1'b0, 8'h00, 5'b00000);

        // Back-to-back 00, FF, A5; A5 ends with bit 1 so the trail is (0,0)
        addVec(1'b1, 8'h00, 5'b00000);
        addZero(1'b1, 8'h00);
        addSync(1'b1, 8'h00);
        addVec(1'b1, 8'h00, 5'b00110);
        addVec(1'b1, 8'h00, 5'b00110);
        addVec(1'b1, 8'h00, 5'b00110);
        addVec(1'b1, 8'hFF, 5'b00111);
        addVec(1'b1, 8'h00, 5'b11110);
        addVec(1'b1, 8'h00, 5'b11110);
        addVec(1'b1, 8'h00, 5'b11110);
        addVec(1'b1, 8'hA5, 5'b11111);
        addVec(1'b1, 8'h00, 5'b10110);
        addVec(1'b1, 8'h00, 5'b10110);
        addVec(1'b1, 8'h00, 5'b01110);
        addVec(1'b0, 8'h00, 5'b01110);
        addTrail(1'b0, 1'b0);
        addVec(1'b0, 8'h00, 5'b00000);

        // One-cycle request pulse: sync-only burst, no handshake, trail (0,0)
        addVec(1'b1, 8'h77, 5'b00000);
        addZero(1'b0, 8'h77);
        addSync(1'b0, 8'h00);
        addTrail(1'b0, 1'b0);
        addVec(1'b0, 8'h00, 5'b00000);

        // Byte 3C then request held through TRAIL: nothing accepted, one IDLE cycle, new ZERO
        addVec(1'b1, 8'h3C, 5'b00000);
        addZero(1'b1, 8'h3C);
        addSync(1'b1, 8'h3C);
        addVec(1'b1, 8'h00, 5'b00110);
        addVec(1'b1, 8'h00, 5'b11110);
        addVec(1'b1, 8'h00, 5'b11110);
        addVec(1'b0, 8'h00, 5'b00110);
        addTrail(1'b1, 1'b1);
        addVec(1'b1, 8'h00, 5'b00000);
        addZero(1'b0, 8'h00);
        addSync(1'b0, 8'h00);
        addTrail(1'b0, 1'b0);
        addVec(1'b0, 8'h00, 5'b00000);

        rst  = 1'b1;
        req  = 1'b0;
        data = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("reset outputs", 16'(outs()), 16'h0000);
`ifdef HS_TX_BYTE_CNT_EN
        checkOutput("reset byte count", tx_byte_cnt, 16'h0000);
`endif
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].req, vecs[i].data);
            checkOutput($sformatf("vec[%0d]", i), 16'(outs()), 16'(vecs[i].exp));
            @(negedge clk);
        end

        // Reset in the middle of a DATA byte, then a full restart
        applyStimulus(1'b1, 8'hFF);
        repeat (12) @(negedge clk);
        #1;
        checkOutput("mid-data pair", 16'(outs()), 16'(5'b11110));
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("after reset", 16'(outs()), 16'h0000);
        rst = 1'b0;
        for (int k = 0; k < ZC; k++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("restart zero[%0d]", k), 16'(outs()), 16'(5'b00110));
        end
        @(negedge clk);
        #1;
        checkOutput("restart sync pair0", 16'(outs()), 16'(5'b00110));
        @(negedge clk);
        #1;
        checkOutput("restart sync pair1", 16'(outs()), 16'(5'b01110));
        req = 1'b0;
        @(negedge clk);
        waitIdle("restart");

`ifdef HS_TX_BYTE_CNT_EN
        // Ten-byte burst: request held until the tenth byte's last pair
        @(negedge clk);
        readyPulses = 0;
        for (int c = 0; c < 50; c++) begin
            applyStimulus(1'b1, 8'(c));
            if (TxReadyHS) readyPulses++;
            @(negedge clk);
        end
        applyStimulus(1'b0, 8'h00);
        waitIdle("count burst");
        checkOutput("ready pulses", 16'(readyPulses), 16'd10);
        checkOutput("byte count after burst", tx_byte_cnt, 16'd10);
        @(negedge clk);
        checkOutput("byte count held", tx_byte_cnt, 16'd10);
        applyStimulus(1'b1, 8'h00);
        @(negedge clk);
        applyStimulus(1'b0, 8'h00);
        checkOutput("byte count cleared", tx_byte_cnt, 16'd0);
        waitIdle("count restart");
`else
        readyPulses = 0;
        checkOutput("idle ready", 16'(TxReadyHS), 16'(readyPulses));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
